grid_game_ctrl: RTL and testbench
=================================

# grid_game_ctrl

Clocked, parametrised board-game controller generalising the tic-tac-toe datapath to a ROWS×COLS grid with configurable win length. It owns the board state, validates moves from a single move port, tracks turn and move count, detects wins by sequentially scanning anchor cells, and can play P2 itself with a deterministic scan-based opponent. It sits between the button/debounce front end (one encoded move per request) and the LED/display back end.

## Interface
- ROWS, default 3: grid rows (≥2)
- COLS, default 3: grid columns (≥2)
- WIN_LEN, default 3: cells in a line needed to win (2 ≤ WIN_LEN ≤ max(ROWS,COLS))
- Derived: N = ROWS*COLS; IW = $clog2(N); CW = $clog2(N+1); cell index = row*COLS + col

- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; full clear
- new_game  in  1  synchronous clear, same effect as reset; reset has priority
- game_mode  in  1  1 = P2 played by internal opponent; sampled on each turn hand-over
- move_valid  in  1  move request
- move_idx  in  IW  requested cell
- move_ready  out  1  controller accepting a human move
- move_reject  out  1  one-cycle pulse: accepted-handshake move was illegal
- cell_p1, cell_p2  out  N  per-cell occupancy; never both 1 for one bit
- p1_turn, p2_turn  out  1  whose turn; both 0 in DONE
- p1_win, p2_win, tie  out  1  sticky result flags
- move_count  out  CW  cells occupied

## Operation
- States: WAIT, CHECK, AI_SCAN, DONE. Registers: board, turn (P1/P2), anchor/scan counter (IW), move_count.
- Reset/new_game: board=0, move_count=0, turn=P1, flags=0, state=WAIT. Resulting outputs: move_ready=1, p1_turn=1, all others 0.
- WAIT: move_ready=1. Handshake = move_valid && move_ready. If move_idx ≥ N or cell occupied: move_reject=1 next cycle, board unchanged, stay WAIT. Else set cell for current player, move_count+1, anchor=0, go CHECK.
- move_valid outside WAIT: ignored, no reject.
- CHECK: one anchor per cycle, index 0..N-1. For the player who just moved, test four lines starting at the anchor: right, down, down-right, down-left; a line is tested only if all WIN_LEN cells lie on the grid. Any hit: set that player's win flag, go DONE (early exit).
- CHECK ends at anchor N-1 without hit: if move_count==N, set tie, go DONE. Else toggle turn; if new turn is P2 and game_mode=1, scan=0, go AI_SCAN; else go WAIT.
- AI_SCAN: one cell per cycle from index 0; first empty cell is claimed as P2 (move_count+1), anchor=0, go CHECK. An empty cell always exists here.
- DONE: flags held; only reset/new_game leaves.
- p1_turn = (turn==P1) && state≠DONE; p2_turn likewise.

## Timing
- Human move accepted at edge ending cycle t: board/move_count updated in t+1; anchor k checked in cycle t+1+k.
- Win at anchor k: flag high from cycle t+2+k.
- No win, human next: move_ready high in cycle t+N+1.
- AI next: AI_SCAN inspects index j in cycle t+N+1+j; AI cell set from t+N+2+j, then CHECK as above.
- move_reject: high exactly cycle t+1 for a rejected handshake at t; move_ready stays high.
- reset/new_game asserted in any state, including mid-CHECK or mid-AI_SCAN: outputs at reset values the next cycle; any partial move discarded.

## Test plan
- Default 3×3, game_mode=0: P1 0, P2 3, P1 1, P2 4, P1 2 -> p1_win=1 two cycles after last accept (anchor 0, right); p1_turn=p2_turn=0; move_count=5.
- Occupied/out-of-range: P1 4 then P2 requests 4, then 9 -> move_reject pulse each, cell_p2=0, p2_turn stays 1, move_count=1.
- Tie: P1 0, P2 2, P1 1, P2 4, P1 5, P2 3, P1 6, P2 7, P1 8 -> tie=1, no win flags, move_count=9, move_ready=0.
- AI mode: P1 4 -> AI takes 0 (cell_p2 bit0 at t+11); P1 1 -> AI takes 2; P1 7 -> p1_win=1 (column 1,4,7).
- new_game asserted mid-CHECK after third move -> next cycle board=0, move_count=0, p1_turn=1, move_ready=1; subsequent moves behave normally.
- ROWS=4, COLS=5, WIN_LEN=4: P1 on 1,7,13,19 (down-right diagonal), P2 on 0,5,10 -> p1_win=1 at anchor 1; no false win on 3-in-a-row.

Source files
------------

// File: rtl/grid_game_ctrl.sv
// grid_game_ctrl: ROWS x COLS board-game controller with move validation, sequential anchor win scan and scan-based P2 opponent
module grid_game_ctrl #(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int WIN_LEN = 3,
    localparam int N = ROWS * COLS,
    localparam int IW = $clog2(N),
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          new_game,
    input  logic          game_mode,
    input  logic          move_valid,
    input  logic [IW-1:0] move_idx,
    output logic          move_ready,
    output logic          move_reject,
    output logic [N-1:0]  cell_p1,
    output logic [N-1:0]  cell_p2,
    output logic          p1_turn,
    output logic          p2_turn,
    output logic          p1_win,
    output logic          p2_win,
    output logic          tie,
    output logic [CW-1:0] move_count
);
    typedef enum logic [1:0] {WAIT, CHECK, AI_SCAN, DONE} state_t;
    localparam logic [IW:0]   NUM  = (IW + 1)'(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [CW-1:0] FULL = CW'(N);
    state_t        state;
    logic          p2;
    logic [IW-1:0] ptr;
    logic [N-1:0]  mine;
    logic [N-1:0]  hit;
    logic          illegal;
    // Cells of the WIN_LEN line from anchor a in direction (dr,dc); zero if it leaves the grid.
    function automatic logic [N-1:0] line_mask(int a, int dr, int dc);
        logic [N-1:0] m;
        int r, c, ok;
        m = '0;
        ok = 1;
        for (int i = 0; i < WIN_LEN; i++) begin
            r = a / COLS + i * dr;
            c = a % COLS + i * dc;
            if (r < 0 || r >= ROWS || c < 0 || c >= COLS) ok = 0;
            else m[r * COLS + c] = 1'b1;
        end
        return ok != 0 ? m : '0;
    endfunction
    function automatic logic full(logic [N-1:0] m, logic [N-1:0] b);
        return (|m) && ((b & m) == m);
    endfunction
    assign mine       = p2 ? cell_p2 : cell_p1;
    assign illegal    = ({1'b0, move_idx} >= NUM) || cell_p1[move_idx] || cell_p2[move_idx];
    assign move_ready = state == WAIT;
    assign p1_turn    = !p2 && state != DONE;
    assign p2_turn    = p2 && state != DONE;
    for (genvar a = 0; a < N; a++) begin : g_anchor
        localparam logic [N-1:0] MR  = line_mask(a, 0, 1);
        localparam logic [N-1:0] MD  = line_mask(a, 1, 0);
        localparam logic [N-1:0] MDR = line_mask(a, 1, 1);
        localparam logic [N-1:0] MDL = line_mask(a, 1, -1);
        assign hit[a] = full(MR, mine) || full(MD, mine) || full(MDR, mine) || full(MDL, mine);
    end
    always_ff @(posedge clk) begin
        if (!reset || new_game) begin
            state       <= WAIT;
            cell_p1     <= '0;
            cell_p2     <= '0;
            p2          <= 1'b0;
            ptr         <= '0;
            move_count  <= '0;
            move_reject <= 1'b0;
            p1_win      <= 1'b0;
            p2_win      <= 1'b0;
            tie         <= 1'b0;
        end else begin
            move_reject <= 1'b0;
            case (state)
                WAIT: if (move_valid) begin
                    if (illegal) move_reject <= 1'b1;
                    else begin
                        if (p2) cell_p2[move_idx] <= 1'b1;
                        else cell_p1[move_idx] <= 1'b1;
                        move_count <= move_count + 1'b1;
                        ptr        <= '0;
                        state      <= CHECK;
                    end
                end
                CHECK: if (hit[ptr]) begin
                    if (p2) p2_win <= 1'b1;
                    else p1_win <= 1'b1;
                    state <= DONE;
                end else if (ptr == LAST) begin
                    if (move_count == FULL) begin
                        tie   <= 1'b1;
                        state <= DONE;
                    end else begin
                        p2    <= !p2;
                        ptr   <= '0;
                        state <= (!p2 && game_mode) ? AI_SCAN : WAIT;
                    end
                end else ptr <= ptr + 1'b1;
                AI_SCAN: if (!(cell_p1[ptr] || cell_p2[ptr])) begin
                    cell_p2[ptr] <= 1'b1;
                    move_count   <= move_count + 1'b1;
                    ptr          <= '0;
                    state        <= CHECK;
                end else ptr <= ptr + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_grid_game_ctrl.sv
// tb_grid_game_ctrl: directed and random games on a 3x3 and a 4x5 (win 4) controller against a board-level reference model
module tb_grid_game_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic new_game = 1'b0;
    logic game_mode = 1'b0;
    logic move_valid = 1'b0;
    logic [4:0] move_idx = '0;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    logic a_ready, a_rej, a_p1t, a_p2t, a_w1, a_w2, a_tie;
    logic [8:0] a_c1, a_c2;
    logic [3:0] a_cnt;
    logic b_ready, b_rej, b_p1t, b_p2t, b_w1, b_w2, b_tie;
    logic [19:0] b_c1, b_c2;
    logic [4:0] b_cnt;

    grid_game_ctrl dut_a (
        .clk(clk), .reset(reset), .new_game(new_game), .game_mode(game_mode),
        .move_valid(move_valid && !sel), .move_idx(move_idx[3:0]),
        .move_ready(a_ready), .move_reject(a_rej), .cell_p1(a_c1), .cell_p2(a_c2),
        .p1_turn(a_p1t), .p2_turn(a_p2t), .p1_win(a_w1), .p2_win(a_w2), .tie(a_tie),
        .move_count(a_cnt)
    );
    grid_game_ctrl #(.ROWS(4), .COLS(5), .WIN_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .new_game(new_game), .game_mode(game_mode),
        .move_valid(move_valid && sel), .move_idx(move_idx),
        .move_ready(b_ready), .move_reject(b_rej), .cell_p1(b_c1), .cell_p2(b_c2),
        .p1_turn(b_p1t), .p2_turn(b_p2t), .p1_win(b_w1), .p2_win(b_w2), .tie(b_tie),
        .move_count(b_cnt)
    );

    logic ready, rej, p1t, p2t, w1, w2, tie_f;
    logic [19:0] c1, c2;
    logic [4:0] cnt;
    always_comb begin
        ready = sel ? b_ready : a_ready;
        rej   = sel ? b_rej : a_rej;
        p1t   = sel ? b_p1t : a_p1t;
        p2t   = sel ? b_p2t : a_p2t;
        w1    = sel ? b_w1 : a_w1;
        w2    = sel ? b_w2 : a_w2;
        tie_f = sel ? b_tie : a_tie;
        c1    = sel ? b_c1 : {11'b0, a_c1};
        c2    = sel ? b_c2 : {11'b0, a_c2};
        cnt   = sel ? b_cnt : {1'b0, a_cnt};
    end

    int R = 3, C = 3, W = 3, N = 9;
    int bd[20];
    int mc, turn, done;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] occ(input int p);
        logic [19:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = (bd[i] == p);
        return v;
    endfunction

    // Lowest anchor from which player p owns a full WIN_LEN line, or -1.
    function automatic int first_anchor(input int p);
        int dr[4], dc[4];
        int res, hits, r, c;
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        res = -1;
        for (int a = 0; a < N; a++)
            for (int d = 0; d < 4; d++) begin
                hits = 0;
                for (int i = 0; i < W; i++) begin
                    r = a / C + i * dr[d];
                    c = a % C + i * dc[d];
                    if (r >= 0 && r < R && c >= 0 && c < C && bd[r * C + c] == p) hits++;
                end
                if (hits == W && res < 0) res = a;
            end
        return res;
    endfunction

    task automatic do_reset(input bit use_ng);
        @(negedge clk);
        move_valid = 1'b0;
        if (use_ng) new_game = 1'b1;
        else reset = 1'b0;
        @(negedge clk);
        new_game = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) bd[i] = 0;
        mc = 0;
        turn = 1;
        done = 0;
        chk("rst_flags", {ready, rej, p1t, p2t, w1, w2, tie_f}, 7'b1010000);
        chk("rst_p1", c1, 0);
        chk("rst_p2", c2, 0);
        chk("rst_count", cnt, 0);
    endtask

    // Entered at the negedge of the cycle after a legal move was taken; follows CHECK and any AI reply.
    task automatic resolve();
        int k, j;
        bit again;
        do begin
            again = 0;
            k = first_anchor(turn);
            chk("cells_p1", c1, occ(1));
            chk("cells_p2", c2, occ(2));
            chk("count", cnt, mc);
            if (k >= 0) begin
                repeat (k) @(negedge clk);
                chk("win_early", turn == 1 ? w1 : w2, 0);
                @(negedge clk);
                chk("win", {w1, w2, tie_f}, turn == 1 ? 3'b100 : 3'b010);
                chk("win_idle", {p1t, p2t, ready}, 0);
                done = 1;
            end else if (mc == N) begin
                repeat (N - 1) @(negedge clk);
                chk("tie_early", tie_f, 0);
                @(negedge clk);
                chk("tie", {w1, w2, tie_f}, 3'b001);
                chk("tie_idle", {p1t, p2t, ready}, 0);
                done = 1;
            end else begin
                repeat (N - 1) @(negedge clk);
                chk("busy", ready, 0);
                @(negedge clk);
                turn = 3 - turn;
                chk("turn", {p1t, p2t}, turn == 1 ? 2'b10 : 2'b01);
                if (turn == 2 && game_mode) begin
                    chk("ai_busy", ready, 0);
                    j = 0;
                    while (bd[j] != 0) j++;
                    repeat (j) @(negedge clk);
                    chk("ai_pre", c2[j], 0);
                    @(negedge clk);
                    bd[j] = 2;
                    mc++;
                    again = 1;
                end else chk("ready", ready, 1);
            end
        end while (again);
    endtask

    task automatic move(input int idx);
        move_valid = 1'b1;
        move_idx = 5'(idx);
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        if (idx >= N || bd[idx] != 0) begin
            chk("reject", {rej, ready}, 2'b11);
            chk("rej_turn", {p1t, p2t}, turn == 1 ? 2'b10 : 2'b01);
            chk("rej_p1", c1, occ(1));
            chk("rej_p2", c2, occ(2));
            chk("rej_count", cnt, mc);
            @(negedge clk);
            chk("reject_end", rej, 0);
        end else begin
            bd[idx] = turn;
            mc++;
            chk("no_reject", rej, 0);
            resolve();
        end
    endtask

    task automatic poke(input int idx);
        move_valid = 1'b1;
        move_idx = 5'(idx);
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        chk("ignored_rej", rej, 0);
        chk("ignored_p1", c1, occ(1));
        chk("ignored_p2", c2, occ(2));
    endtask

    initial begin
        int q[$];
        int idx, steps;
        do_reset(0);
        game_mode = 1'b0;
        move(0); move(3); move(1); move(4); move(2);
        poke(5);

        do_reset(1);
        move(4); move(4); move(9);

        do_reset(0);
        move(0); move(2); move(1); move(4); move(5); move(3); move(6); move(7); move(8);

        do_reset(1);
        game_mode = 1'b1;
        move(4); move(1); move(7);

        do_reset(0);
        game_mode = 1'b0;
        move(0); move(3);
        move_valid = 1'b1;
        move_idx = 5'd1;
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_check_busy", ready, 0);
        do_reset(1);
        move(0); move(3); move(1); move(4); move(2);

        do_reset(0);
        game_mode = 1'b1;
        move_valid = 1'b1;
        move_idx = 5'd0;
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_ai_busy", ready, 0);
        do_reset(0);

        for (int g = 0; g < 8; g++) begin
            do_reset(g % 3 == 0);
            game_mode = (g % 2) != 0;
            steps = 0;
            while (!done && steps < 30) begin
                q.delete();
                for (int i = 0; i < N; i++) if (bd[i] == 0) q.push_back(i);
                idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : q[$urandom_range(0, q.size() - 1)];
                move(idx);
                steps++;
            end
        end

        sel = 1'b1;
        R = 4; C = 5; W = 4; N = 20;
        game_mode = 1'b0;
        do_reset(0);
        move(1); move(0); move(7); move(5); move(13); move(10); move(25); move(19);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
